// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I memory operation at a time from the
// execute stage, issues a single access to the dtcm and returns a one-cycle
// writeback pulse. Sequence is IDLE -> REQ -> WAIT -> DONE -> IDLE; illegal
// width codes go straight from IDLE to DONE with lsu_err set.
// Optional build macro LSU_MISALIGN_CHK_EN: when defined, halfword accesses
// at odd addresses and word accesses not on a 4-byte boundary are rejected
// like illegal width codes; when undefined they are issued unchanged.
module lsu #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic          lsu_is_store,
  input  logic [2:0]    lsu_funct3,
  input  logic [AW-1:0] lsu_rs1,
  input  logic [AW-1:0] lsu_imm,
  input  logic [DW-1:0] lsu_rs2,
  input  logic [4:0]    lsu_rd,
  output logic          req_to_dtcm,
  output logic          load_to_dtcm,
  output logic          store_to_dtcm,
  output logic [AW-1:0] addr_to_dtcm,
  output logic [DW-1:0] store_data_to_dtcm,
  output logic [3:0]    store_mask_to_dtcm,
  input  logic          res_from_dtcm,
  input  logic [DW-1:0] data_from_dtcm,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          lsu_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic          op_store;
  logic [2:0]    op_funct3;
  logic [4:0]    op_rd;

  logic [AW-1:0] eff_addr;
  logic          bad_funct3;
  logic          misaligned;
  logic [DW-1:0] st_data;
  logic [3:0]    st_mask;

  // Effective address, legality and store lane formatting of the offered op
  always_comb begin
    eff_addr   = lsu_rs1 + lsu_imm;
    bad_funct3 = lsu_is_store ? (lsu_funct3 > 3'd2)
                              : (lsu_funct3 == 3'b011 || lsu_funct3 == 3'b110 ||
                                 lsu_funct3 == 3'b111);
`ifdef LSU_MISALIGN_CHK_EN
    misaligned = (lsu_funct3[1:0] == 2'b01 && eff_addr[0]) ||
                 (lsu_funct3[1:0] == 2'b10 && eff_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    st_data = '0;
    st_mask = '0;
    if (lsu_is_store) begin
      case (lsu_funct3)
        3'b000: begin
          st_data = {{(DW-8){1'b0}}, lsu_rs2[7:0]};
          st_mask = 4'b1110;
        end
        3'b001: begin
          st_data = {{(DW-16){1'b0}}, lsu_rs2[15:0]};
          st_mask = 4'b1100;
        end
        default: begin
          st_data = lsu_rs2;
          st_mask = 4'b0000;
        end
      endcase
    end
  end

  // Extract and extend the addressed bytes of a load response
  function automatic logic [DW-1:0] load_ext(input logic [2:0] f3, input logic [DW-1:0] d);
    case (f3)
      3'b000:  return {{(DW-8){d[7]}}, d[7:0]};
      3'b100:  return {{(DW-8){1'b0}}, d[7:0]};
      3'b001:  return {{(DW-16){d[15]}}, d[15:0]};
      3'b101:  return {{(DW-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Operation sequencer with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      lsu_ready          <= 1'b1;
      op_store           <= 1'b0;
      op_funct3          <= '0;
      op_rd              <= '0;
      req_to_dtcm        <= 1'b0;
      load_to_dtcm       <= 1'b0;
      store_to_dtcm      <= 1'b0;
      addr_to_dtcm       <= '0;
      store_data_to_dtcm <= '0;
      store_mask_to_dtcm <= '0;
      wb_valid           <= 1'b0;
      wb_we              <= 1'b0;
      wb_rd              <= '0;
      wb_data            <= '0;
      lsu_err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            lsu_ready <= 1'b0;
            op_store  <= lsu_is_store;
            op_funct3 <= lsu_funct3;
            op_rd     <= lsu_rd;
            if (bad_funct3 || misaligned) begin
              state    <= DONE;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= lsu_rd;
              wb_data  <= '0;
              lsu_err  <= 1'b1;
            end else begin
              state              <= REQ;
              req_to_dtcm        <= 1'b1;
              load_to_dtcm       <= ~lsu_is_store;
              store_to_dtcm      <= lsu_is_store;
              addr_to_dtcm       <= eff_addr;
              store_data_to_dtcm <= st_data;
              store_mask_to_dtcm <= st_mask;
            end
          end
        end
        REQ: begin
          state              <= WAIT;
          req_to_dtcm        <= 1'b0;
          load_to_dtcm       <= 1'b0;
          store_to_dtcm      <= 1'b0;
          addr_to_dtcm       <= '0;
          store_data_to_dtcm <= '0;
          store_mask_to_dtcm <= '0;
        end
        WAIT: begin
          if (res_from_dtcm) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_we    <= ~op_store && (op_rd != 5'd0);
            wb_rd    <= op_rd;
            wb_data  <= op_store ? '0 : load_ext(op_funct3, data_from_dtcm);
            lsu_err  <= 1'b0;
          end
        end
        DONE: begin
          state     <= IDLE;
          lsu_ready <= 1'b1;
          wb_valid  <= 1'b0;
          wb_we     <= 1'b0;
          wb_rd     <= '0;
          wb_data   <= '0;
          lsu_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed operations with hand-computed expectations,
// then randomized traffic checked every cycle against a timeline model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_is_store = 1'b0;
  logic [2:0]  lsu_funct3 = '0;
  logic [31:0] lsu_rs1 = '0;
  logic [31:0] lsu_imm = '0;
  logic [31:0] lsu_rs2 = '0;
  logic [4:0]  lsu_rd = '0;
  logic        req_to_dtcm, load_to_dtcm, store_to_dtcm;
  logic [31:0] addr_to_dtcm, store_data_to_dtcm;
  logic [3:0]  store_mask_to_dtcm;
  logic        res_from_dtcm = 1'b0;
  logic [31:0] data_from_dtcm = '0;
  logic        wb_valid, wb_we, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  lsu #(.DW(32), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_is_store(lsu_is_store), .lsu_funct3(lsu_funct3),
    .lsu_rs1(lsu_rs1), .lsu_imm(lsu_imm), .lsu_rs2(lsu_rs2), .lsu_rd(lsu_rd),
    .req_to_dtcm(req_to_dtcm), .load_to_dtcm(load_to_dtcm),
    .store_to_dtcm(store_to_dtcm), .addr_to_dtcm(addr_to_dtcm),
    .store_data_to_dtcm(store_data_to_dtcm), .store_mask_to_dtcm(store_mask_to_dtcm),
    .res_from_dtcm(res_from_dtcm), .data_from_dtcm(data_from_dtcm),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference arithmetic for load results and store lanes
  function automatic int unsigned op_size(input bit [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit [31:0] exp_load(input bit [2:0] f3, input bit [31:0] d);
    longint n, v;
    if (op_size(f3) == 4) return d;
    n = 8 * longint'(op_size(f3));
    v = longint'(d) % (longint'(1) << n);
    if (!f3[2] && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
    return 32'(v);
  endfunction

  // Model: each accepted op is described by its acceptance cycle and the
  // cycle in which its writeback pulse must appear.
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0;
  int          m_T = -10;
  int          m_done = -1;
  bit          m_legal, m_st, m_we, m_err;
  bit [4:0]    m_rd;
  bit [2:0]    m_f3;
  bit [31:0]   m_addr, m_sdata, m_wdata;
  bit [3:0]    m_mask;

  always @(posedge clk) begin : model
    int unsigned sz;
    if (rst) begin
      m_busy = 1'b0;
      m_done = -1;
    end else if (m_busy) begin
      if (cyc == m_done) m_busy = 1'b0;
      else if (m_legal && m_done < 0 && cyc >= m_T + 2 && res_from_dtcm) begin
        m_done  = cyc + 1;
        m_we    = !m_st && (m_rd != 5'd0);
        m_wdata = m_st ? 32'd0 : exp_load(m_f3, data_from_dtcm);
        m_err   = 1'b0;
      end
    end else if (lsu_valid) begin
      m_busy = 1'b1;
      m_T    = cyc;
      m_st   = lsu_is_store;
      m_f3   = lsu_funct3;
      m_rd   = lsu_rd;
      m_addr = lsu_rs1 + lsu_imm;
      sz     = op_size(lsu_funct3);
      m_legal = lsu_is_store ? (lsu_funct3 <= 3'd2)
                             : !(lsu_funct3 == 3'd3 || lsu_funct3 == 3'd6 || lsu_funct3 == 3'd7);
`ifdef LSU_MISALIGN_CHK_EN
      if (m_addr % sz != 0) m_legal = 1'b0;
`endif
      m_mask  = (!m_st || sz == 4) ? 4'b0000 : (sz == 2) ? 4'b1100 : 4'b1110;
      m_sdata = (sz == 4) ? lsu_rs2 : 32'(longint'(lsu_rs2) % (longint'(1) << (8 * sz)));
      if (m_legal) m_done = -1;
      else begin
        m_done  = cyc + 1;
        m_we    = 1'b0;
        m_err   = 1'b1;
        m_wdata = 32'd0;
      end
    end
    cyc++;
  end

  // Compare process: outputs of the current cycle against the model
  always @(negedge clk) begin : compare
    bit exp_req, exp_wb;
    if (chk_en) begin
      exp_req = m_busy && m_legal && (cyc == m_T + 1);
      exp_wb  = m_busy && (cyc == m_done);
      chk("lsu_ready", lsu_ready, !m_busy);
      chk("req_to_dtcm", req_to_dtcm, exp_req);
      chk("load_to_dtcm", load_to_dtcm, exp_req && !m_st);
      chk("store_to_dtcm", store_to_dtcm, exp_req && m_st);
      if (exp_req) begin
        chk("addr_to_dtcm", addr_to_dtcm, m_addr);
        chk("store_mask", store_mask_to_dtcm, m_mask);
        if (m_st) chk("store_data", store_data_to_dtcm, m_sdata);
      end
      chk("wb_valid", wb_valid, exp_wb);
      if (exp_wb) begin
        chk("wb_we", wb_we, m_we);
        chk("lsu_err", lsu_err, m_err);
        chk("wb_data", wb_data, m_wdata);
        chk("wb_rd", wb_rd, m_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with a one-cycle dtcm response and literal expectations
  task automatic dir_op(input bit st, input bit [2:0] f3, input bit [31:0] rs1, imm, rs2,
                        input bit [4:0] rd, input bit [31:0] mem, input bit exp_req,
                        input bit [31:0] exp_addr, exp_sdata, input bit [3:0] exp_mask,
                        input bit exp_we, exp_err, input bit [31:0] exp_wdata);
    lsu_valid = 1'b1; lsu_is_store = st; lsu_funct3 = f3;
    lsu_rs1 = rs1; lsu_imm = imm; lsu_rs2 = rs2; lsu_rd = rd; res_from_dtcm = 1'b0;
    @(negedge clk); chk("d_ready_T", lsu_ready, 1);
    tick(); lsu_valid = 1'b0;
    @(negedge clk);
    chk("d_req", req_to_dtcm, exp_req);
    if (exp_req) begin
      chk("d_store_q", store_to_dtcm, st);
      chk("d_load_q", load_to_dtcm, !st);
      chk("d_addr", addr_to_dtcm, exp_addr);
      chk("d_mask", store_mask_to_dtcm, exp_mask);
      if (st) chk("d_sdata", store_data_to_dtcm, exp_sdata);
      tick(); res_from_dtcm = 1'b1; data_from_dtcm = mem;
      @(negedge clk); chk("d_wb_early", wb_valid, 0);
      tick(); res_from_dtcm = 1'b0;
      @(negedge clk);
    end
    chk("d_wb_valid", wb_valid, 1);
    chk("d_wb_we", wb_we, exp_we);
    chk("d_lsu_err", lsu_err, exp_err);
    chk("d_wb_data", wb_data, exp_wdata);
    chk("d_wb_rd", wb_rd, rd);
    tick();
    @(negedge clk);
    chk("d_ready_back", lsu_ready, 1);
    chk("d_wb_clear", wb_valid, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_req", req_to_dtcm, 0);
    chk("rst_load", load_to_dtcm, 0);
    chk("rst_store", store_to_dtcm, 0);
    chk("rst_addr", addr_to_dtcm, 0);
    chk("rst_sdata", store_data_to_dtcm, 0);
    chk("rst_mask", store_mask_to_dtcm, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", lsu_err, 0);
    chk_en = 1'b1;
    tick(); rst = 1'b0;

    // st f3 rs1 imm rs2 rd mem | req addr sdata mask we err wdata
    dir_op(1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1, 32'h0,
           1, 32'h104, 32'hDEADBEEF, 4'b0000, 0, 0, 32'h0);
    dir_op(0, 3'b000, 32'h100, 32'h4, 32'h0, 5'd3, 32'hDEADBEEF,
           1, 32'h104, 32'h0, 4'b0000, 1, 0, 32'hFFFFFFEF);
    dir_op(0, 3'b100, 32'h100, 32'h4, 32'h0, 5'd3, 32'hDEADBEEF,
           1, 32'h104, 32'h0, 4'b0000, 1, 0, 32'h000000EF);
    dir_op(0, 3'b101, 32'h100, 32'h4, 32'h0, 5'd4, 32'hDEADBEEF,
           1, 32'h104, 32'h0, 4'b0000, 1, 0, 32'h0000BEEF);
    dir_op(0, 3'b001, 32'h100, 32'h4, 32'h0, 5'd4, 32'hDEADBEEF,
           1, 32'h104, 32'h0, 4'b0000, 1, 0, 32'hFFFFBEEF);
    dir_op(0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd31, 32'hDEADBEEF,
           1, 32'h104, 32'h0, 4'b0000, 1, 0, 32'hDEADBEEF);
    dir_op(1, 3'b001, 32'h200, 32'h2, 32'h12345678, 5'd2, 32'h0,
           1, 32'h202, 32'h00005678, 4'b1100, 0, 0, 32'h0);
    dir_op(1, 3'b000, 32'h200, 32'h3, 32'h12345678, 5'd2, 32'h0,
           1, 32'h203, 32'h00000078, 4'b1110, 0, 0, 32'h0);
    dir_op(0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd5, 32'h0BADF00D,
           1, 32'h00000004, 32'h0, 4'b0000, 1, 0, 32'h0BADF00D);
    dir_op(0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd6, 32'h0,
           0, 32'h0, 32'h0, 4'b0000, 0, 1, 32'h0);
    dir_op(1, 3'b100, 32'h100, 32'h0, 32'h55, 5'd6, 32'h0,
           0, 32'h0, 32'h0, 4'b0000, 0, 1, 32'h0);
    dir_op(0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd0, 32'hCAFEF00D,
           1, 32'h0, 32'h0, 4'b0000, 0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_CHK_EN
    dir_op(0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd7, 32'h0,
           0, 32'h0, 32'h0, 4'b0000, 0, 1, 32'h0);
`else
    dir_op(0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd7, 32'hA5A5A5A5,
           1, 32'h102, 32'h0, 4'b0000, 1, 0, 32'hA5A5A5A5);
`endif

    // lsu_valid held high: the second op is taken only once ready returns
    lsu_valid = 1'b1; lsu_is_store = 1'b0; lsu_funct3 = 3'b010;
    lsu_rs1 = 32'h100; lsu_imm = 32'h0; lsu_rd = 5'd0;
    @(negedge clk); chk("h_ready_T", lsu_ready, 1);
    tick(); @(negedge clk); chk("h_req_T1", req_to_dtcm, 1); chk("h_ready_T1", lsu_ready, 0);
    tick(); res_from_dtcm = 1'b1; data_from_dtcm = 32'h12345678;
    @(negedge clk); chk("h_ready_T2", lsu_ready, 0);
    tick(); res_from_dtcm = 1'b0;
    @(negedge clk); chk("h_wb_T3", wb_valid, 1); chk("h_we_T3", wb_we, 0);
    tick(); @(negedge clk); chk("h_ready_T4", lsu_ready, 1); chk("h_req_T4", req_to_dtcm, 0);
    tick(); lsu_valid = 1'b0;
    @(negedge clk); chk("h_req_T5", req_to_dtcm, 1);
    tick(); res_from_dtcm = 1'b1;
    tick(); res_from_dtcm = 1'b0;
    @(negedge clk); chk("h_wb2", wb_valid, 1);
    tick(); tick();

    // reset in WAIT, then a stray response
    lsu_valid = 1'b1; lsu_funct3 = 3'b010; lsu_rd = 5'd9;
    tick(); lsu_valid = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; res_from_dtcm = 1'b1;
    @(negedge clk); chk("r_ready", lsu_ready, 1); chk("r_wb", wb_valid, 0);
    tick(); res_from_dtcm = 1'b0;
    @(negedge clk); chk("r_wb2", wb_valid, 0); chk("r_ready2", lsu_ready, 1);
    tick();
    @(negedge clk); chk("r_wb3", wb_valid, 0);
    tick();

    // randomized traffic: stray responses, resets in any state, busy-time valids
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      lsu_valid      = $urandom_range(0, 1);
      lsu_is_store   = $urandom_range(0, 1);
      lsu_funct3     = 3'($urandom_range(0, 7));
      lsu_rs1        = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
      lsu_imm        = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                                   : 32'($urandom_range(0, 64));
      lsu_rs2        = $urandom;
      lsu_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      res_from_dtcm  = ($urandom_range(0, 2) == 0);
      data_from_dtcm = $urandom;
      tick();
    end
    rst = 1'b0; lsu_valid = 1'b0; res_from_dtcm = 1'b0;
    tick(); tick();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
